// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter.
// Holds the FSM state encoding and the bit-counter width helper.
// No logic; imported by the controller and the shifter.
package piso_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // Bits needed to count 0..width-1; never narrower than one bit.
    function automatic int cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_shift.sv
// Shift register with parallel load and a per-word direction select.
// Latency: loaded word's first bit is on bit_o the cycle after load_i.
// No backpressure; the controller decides when to load and shift.
module piso_shift
    import piso_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             lsb_first_i,
    output logic             bit_o
);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic             lsb_q, lsb_d;

    // Next contents: load wins over shift; direction is latched with the word.
    always_comb begin
        shift_d = shift_q;
        lsb_d   = lsb_q;
        if (load_i) begin
            shift_d = data_i;
            lsb_d   = lsb_first_i;
        end else if (shift_i) begin
            shift_d = lsb_q ? (shift_q >> 1) : (shift_q << 1);
        end
    end

    // Register the shifter and its direction bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            lsb_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            lsb_q   <= lsb_d;
        end
    end

    assign bit_o = lsb_q ? shift_q[0] : shift_q[WIDTH-1];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Serialises WIDTH-bit words onto so with frame/done, GAP idle cycles between words.
// Latency: first bit one cycle after accept; a buffered word starts right after the gap.
// Backpressure: one-entry buffer; in_ready drops while it is full.
module piso_tx_ctrl
    import piso_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             lsb_first,
    output logic             so,
    output logic             frame,
    output logic             done,
    output logic             busy
);

    localparam int             CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0]  BIT_LAST = CW'(WIDTH - 1);
    localparam logic [2:0]     GAP_LAST = (GAP == 0) ? 3'd0 : 3'(GAP - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]       gap_cnt_q, gap_cnt_d;
    logic             buf_full_q, buf_full_d;
    logic [WIDTH-1:0] buf_dat_q, buf_dat_d;
    logic             buf_lsb_q, buf_lsb_d;

    logic             accept;
    logic             boundary;
    logic             sh_load, sh_shift, sh_lsb, sh_bit;
    logic [WIDTH-1:0] sh_dat;

    // Held low during reset so a requester never sees a ready while state is cleared.
    assign in_ready = rst & ~buf_full_q;
    assign accept   = in_valid & in_ready;

    // Next-state, counters, buffer and shifter controls.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        buf_full_d = buf_full_q;
        buf_dat_d  = buf_dat_q;
        buf_lsb_d  = buf_lsb_q;
        sh_load    = 1'b0;
        sh_shift   = 1'b0;
        sh_dat     = in_data;
        sh_lsb     = lsb_first;
        boundary   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sh_load   = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q == BIT_LAST && GAP == 0) begin
                    boundary = 1'b1;
                end else begin
                    if (bit_cnt_q == BIT_LAST) begin
                        gap_cnt_d = '0;
                        state_d   = ST_GAP;
                    end else begin
                        sh_shift  = 1'b1;
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                    if (accept) begin
                        buf_full_d = 1'b1;
                        buf_dat_d  = in_data;
                        buf_lsb_d  = lsb_first;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    boundary = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 3'd1;
                    if (accept) begin
                        buf_full_d = 1'b1;
                        buf_dat_d  = in_data;
                        buf_lsb_d  = lsb_first;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Word boundary: buffered word first, else a word offered right now, else idle.
        // A full buffer keeps in_ready low, so both cannot happen together.
        if (boundary) begin
            if (buf_full_q) begin
                sh_load    = 1'b1;
                sh_dat     = buf_dat_q;
                sh_lsb     = buf_lsb_q;
                buf_full_d = 1'b0;
                bit_cnt_d  = '0;
                state_d    = ST_SHIFT;
            end else if (accept) begin
                sh_load   = 1'b1;
                bit_cnt_d = '0;
                state_d   = ST_SHIFT;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // State, counters and buffer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            buf_full_q <= 1'b0;
            buf_dat_q  <= '0;
            buf_lsb_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            buf_full_q <= buf_full_d;
            buf_dat_q  <= buf_dat_d;
            buf_lsb_q  <= buf_lsb_d;
        end
    end

    piso_shift #(.WIDTH(WIDTH)) u_shift (
        .clk         (clk),
        .rst         (rst),
        .load_i      (sh_load),
        .shift_i     (sh_shift),
        .data_i      (sh_dat),
        .lsb_first_i (sh_lsb),
        .bit_o       (sh_bit)
    );

    assign frame = (state_q == ST_SHIFT);
    assign so    = frame & sh_bit;
    assign done  = frame && (bit_cnt_q == BIT_LAST);
    assign busy  = (state_q != ST_IDLE) || buf_full_q;

endmodule

// File: tb/tb_piso_tx_ctrl.sv
module tb_piso_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       va, la, ra, so_a, frame_a, done_a, busy_a;
    logic [3:0] da;
    logic       vb, lb, rb, so_b, frame_b, done_b, busy_b;
    logic [3:0] db;
    logic [7:0] seq;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    piso_tx_ctrl #(.WIDTH(4), .GAP(1)) u_a (
        .clk(clk), .rst(rst), .in_valid(va), .in_ready(ra), .in_data(da),
        .lsb_first(la), .so(so_a), .frame(frame_a), .done(done_a), .busy(busy_a)
    );

    piso_tx_ctrl #(.WIDTH(4), .GAP(0)) u_b (
        .clk(clk), .rst(rst), .in_valid(vb), .in_ready(rb), .in_data(db),
        .lsb_first(lb), .so(so_b), .frame(frame_b), .done(done_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {so, frame, done}
    task automatic chk_a(input string tag, input logic [2:0] e);
        chk(tag, {5'd0, so_a, frame_a, done_a}, {5'd0, e});
    endtask

    task automatic chk_b(input string tag, input logic [2:0] e);
        chk(tag, {5'd0, so_b, frame_b, done_b}, {5'd0, e});
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0;
        va = 0; la = 0; da = '0;
        vb = 0; lb = 0; db = '0;

        // Reset values: {so, frame, done, busy, in_ready} all zero
        #3;
        chk("rst_a", {3'd0, so_a, frame_a, done_a, busy_a, ra}, 8'h00);
        chk("rst_b", {3'd0, so_b, frame_b, done_b, busy_b, rb}, 8'h00);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rdy_after_rst_a", {7'd0, ra}, 8'h01);
        chk("rdy_after_rst_b", {7'd0, rb}, 8'h01);

        // MSB-first 0100
        va = 1; da = 4'b0100; la = 0;
        tick(); va = 0; da = '0;
        chk_a("msb_b1", 3'b010);
        tick(); chk_a("msb_b2", 3'b110);
        tick(); chk_a("msb_b3", 3'b010);
        tick(); chk_a("msb_b4", 3'b011);
        tick(); chk_a("msb_gap", 3'b000);
        chk("msb_gap_busy", {7'd0, busy_a}, 8'h01);
        tick(); chk_a("msb_idle", 3'b000);
        chk("msb_idle_busy", {7'd0, busy_a}, 8'h00);

        // LSB-first 1110; lsb_first/data changed after capture must be ignored
        va = 1; da = 4'b1110; la = 1;
        tick(); va = 0; la = 0; da = 4'b0000;
        chk_a("lsb_b1", 3'b010);
        tick(); chk_a("lsb_b2", 3'b110);
        tick(); chk_a("lsb_b3", 3'b110);
        tick(); chk_a("lsb_b4", 3'b111);
        tick(); chk_a("lsb_gap", 3'b000);
        tick(); chk_a("lsb_idle", 3'b000);

        // Back-to-back 1010 then 1000, then 0011 held under backpressure
        va = 1; da = 4'b1010; la = 0;
        tick();
        chk_a("b2b_c1", 3'b110); chk("b2b_rdy1", {7'd0, ra}, 8'h01);
        da = 4'b1000;
        tick();
        chk_a("b2b_c2", 3'b010); chk("b2b_rdy2", {7'd0, ra}, 8'h00);
        da = 4'b0011;
        tick(); chk_a("b2b_c3", 3'b110); chk("bp_rdy3", {7'd0, ra}, 8'h00);
        tick(); chk_a("b2b_c4", 3'b011); chk("bp_rdy4", {7'd0, ra}, 8'h00);
        tick(); chk_a("b2b_gap", 3'b000); chk("bp_rdy5", {7'd0, ra}, 8'h00);
        chk("b2b_gap_busy", {7'd0, busy_a}, 8'h01);
        tick(); chk_a("w2_b1", 3'b110); chk("bp_rdy6", {7'd0, ra}, 8'h01);
        tick(); va = 0; da = '0;
        chk_a("w2_b2", 3'b010); chk("bp_rdy7", {7'd0, ra}, 8'h00);
        tick(); chk_a("w2_b3", 3'b010);
        tick(); chk_a("w2_b4", 3'b011);
        tick(); chk_a("w2_gap", 3'b000);
        tick(); chk_a("w3_b1", 3'b010); chk("bp_rdy11", {7'd0, ra}, 8'h01);
        tick(); chk_a("w3_b2", 3'b010);
        tick(); chk_a("w3_b3", 3'b110);
        tick(); chk_a("w3_b4", 3'b111);
        tick(); chk_a("w3_gap", 3'b000);
        tick(); chk_a("w3_idle", 3'b000);
        chk("w3_idle_busy", {7'd0, busy_a}, 8'h00);

        // Accept on the final gap cycle starts the next word with no idle cycle
        va = 1; da = 4'b0100;
        tick(); va = 0;
        tick(); tick(); tick();
        chk_a("lastgap_b4", 3'b011);
        tick();
        chk_a("lastgap_gap", 3'b000);
        va = 1; da = 4'b0001;
        tick(); va = 0; da = '0;
        chk_a("lastgap_n1", 3'b010);
        tick(); chk_a("lastgap_n2", 3'b010);
        tick(); chk_a("lastgap_n3", 3'b010);
        tick(); chk_a("lastgap_n4", 3'b111);
        tick(); tick();
        chk("lastgap_idle_busy", {7'd0, busy_a}, 8'h00);

        // Reset mid-frame with a buffered word
        va = 1; da = 4'b1111;
        tick(); da = 4'b0101;
        tick(); va = 0; da = '0;
        chk_a("mid_b2", 3'b110);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_async", {3'd0, so_a, frame_a, done_a, busy_a, ra}, 8'h00);
        tick();
        chk("mid_rst_held", {3'd0, so_a, frame_a, done_a, busy_a, ra}, 8'h00);
        rst = 1'b1;
        #1;
        chk("mid_rel_rdy", {6'd0, busy_a, ra}, 8'h01);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk_a("mid_no_residue", 3'b000);
        end

        // GAP=0: 1001 then 0110 back-to-back, frame continuous for 8 cycles
        seq = 8'b1001_0110;
        vb = 1; db = 4'b1001; lb = 0;
        tick();
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) tick();
            if (k == 2) begin vb = 0; db = '0; end
            chk_b("g0_cont", {seq[8-k], 1'b1, (k == 4 || k == 8)});
            if (k == 1) db = 4'b0110;
        end
        tick(); chk_b("g0_end", 3'b000);
        chk("g0_end_busy", {7'd0, busy_b}, 8'h00);

        // GAP=0: accept on the last bit with empty buffer continues the frame
        vb = 1; db = 4'b1100;
        tick(); vb = 0; db = '0;
        tick(); tick(); tick();
        chk_b("g0_last_b4", 3'b011);
        chk("g0_last_rdy", {7'd0, rb}, 8'h01);
        vb = 1; db = 4'b0011; lb = 1;
        tick(); vb = 0; db = '0; lb = 0;
        chk_b("g0_next_b1", 3'b110);
        tick(); chk_b("g0_next_b2", 3'b110);
        tick(); chk_b("g0_next_b3", 3'b010);
        tick(); chk_b("g0_next_b4", 3'b011);
        tick(); chk_b("g0_next_idle", 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piso_tx_ctrl.md
PISO_TX_CTRL -- requirements
Module: piso_tx_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the number of bits per parallel word (legal range 2..16).
REQ-002 The block SHALL have parameter GAP, default 1, meaning the number of idle cycles inserted after each word (legal range 0..7).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the requester offers in_data.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a word this cycle.
REQ-007 The block SHALL have port in_data, input, WIDTH bits: the parallel word.
REQ-008 The block SHALL have port lsb_first, input, 1 bit: bit order for the offered word (1 = bit 0 first, 0 = MSB first).
REQ-009 The block SHALL have port so, output, 1 bit: the serial data out.
REQ-010 The block SHALL have port frame, output, 1 bit: high while so carries a valid data bit.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse on the last bit of each word.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE or the buffer is occupied.

Function
REQ-013 A word SHALL be accepted on a rising edge when in_valid and in_ready are both high; in_data and lsb_first SHALL be captured together on that edge and ignored afterwards.
REQ-014 in_ready SHALL be the inverse of the registered buffer-full flag, with no combinational path from in_valid.
REQ-015 The FSM SHALL have three states: IDLE, SHIFT and GAP.
REQ-016 IDLE to SHIFT: on an accept in IDLE, the word SHALL load directly into the shift register, and the first bit SHALL appear on so with frame high in the cycle after the accept.
REQ-017 SHIFT duration and counter: SHIFT SHALL last exactly WIDTH cycles, counted by a bit counter running 0..WIDTH-1.
REQ-018 SHIFT bit order: so SHALL present one bit per cycle in the captured order.
REQ-019 done SHALL pulse high in the cycle the counter equals WIDTH-1.
REQ-020 SHIFT exit: after the last bit the FSM SHALL enter GAP; when GAP=0 it SHALL instead go straight to SHIFT (buffer full) or IDLE (buffer empty).
REQ-021 GAP state: GAP SHALL last GAP cycles with frame=0 and so=0; when it ends, the FSM SHALL enter SHIFT if the buffer is full, else IDLE.
REQ-022 Buffer: there SHALL be a one-entry buffer; an accept in SHIFT or GAP SHALL write to the buffer.
REQ-023 Buffer-to-shifter transfer: the buffer SHALL transfer into the shift register on the cycle SHIFT is entered from GAP or SHIFT, and the buffer SHALL be freed on that edge, so in_ready rises the next cycle.
REQ-024 Simultaneous accept and transfer: an accept in the same cycle as a buffer-to-shifter transfer cannot occur (in_ready is low) and SHALL NOT be required.
REQ-025 Accept on the final cycle: an accept on the final GAP cycle, or on the last SHIFT cycle with GAP=0, with the buffer empty, SHALL start the new word with no further idle cycle.
REQ-026 Outputs outside frames: so SHALL be 0 whenever frame is 0.
REQ-027 When GAP=0 and the buffer is full, frame SHALL stay continuously high across word boundaries.

Reset
REQ-028 While rst is low, the state SHALL be IDLE, and the counter, shift register and buffer SHALL be cleared.
REQ-029 While rst is low, so=0, frame=0, done=0, busy=0 and in_ready=0.
REQ-030 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-031 Reset asserted mid-frame SHALL force every output to its reset value immediately (asynchronously), discard the buffered word, and emit no done pulse.

Structure
REQ-032 The state encoding (IDLE/SHIFT/GAP) and the counter-width function (clog2 of WIDTH) SHALL live in the shared package piso_pkg.
REQ-033 The shift register SHALL be a sub-module piso_shift (parallel load, shift, and a direction select).
REQ-034 piso_tx_ctrl SHALL contain the FSM, the bit counter, the gap counter and the buffer.

Verification (WIDTH=4, GAP=1 unless noted)
REQ-035 MSB-first single word: accept 4'b0100 with lsb_first=0 from IDLE -> so=0,1,0,0 on cycles 1-4 after the accept, frame high on those 4 cycles, done on cycle 4, then 1 gap cycle, then IDLE.
REQ-036 LSB-first single word: accept 4'b1110 with lsb_first=1 -> so=0,1,1,1, done on the 4th bit.
REQ-037 Back-to-back words: accept 4'b1010 (MSB first), then 4'b1000 on the next cycle -> so=1,0,1,0, one cycle with frame=0, then 1,0,0,0; in_ready low from the buffer write until the transfer.
REQ-038 Backpressure: offer a third word while the buffer is full -> in_ready=0, and in_valid held with data 4'b0011 is accepted only after in_ready returns to 1; the word is serialized intact.
REQ-039 Reset mid-frame: assert rst low after the 2nd bit of 4'b1111 with a buffered word -> so=0, frame=0, busy=0 immediately, no done pulse; after release, in_ready=1 and no residual bits are output.
REQ-040 GAP=0 continuous frame: with GAP=0, send 4'b1001 then 4'b0110 back-to-back -> frame high for 8 consecutive cycles, so=1,0,0,1,0,1,1,0, and done pulses on cycles 4 and 8.
